ntt_coeff_loader: RTL and testbench

- Input stage directly upstream of the flat NTT core.
- Accepts polynomial coefficients serially, one N-bit word per accepted handshake, and reduces each one once modulo Q.
- Assembles D coefficients into a double-buffered D*N-bit frame, in natural or bit-reversed lane order.
- Presents that frame on the core's parallel input `a` for the cycle in which the core samples it (`core_load`).

---
 rtl/ntt_coeff_loader.sv | 142 ++++++++++++++
 tb/tb_ntt_coeff_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coeff_loader.sv
// Serial-to-parallel coefficient loader for the flat NTT core: reduces each
// accepted word once mod Q and double-buffers D of them into the core frame.
module ntt_coeff_loader #(
    parameter int N      = 17,
    parameter int D      = 8,
    parameter int Q      = 65537,
    parameter int BITREV = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           core_load,
    output logic [D*N-1:0] a,
    output logic           frame_pending,
    output logic           underrun,
    output logic [15:0]    frames_done
);

    localparam int             IW       = $clog2(D);
    localparam logic [N-1:0]   Q_N      = N'(Q);
    localparam logic [IW-1:0]  LAST_IDX = IW'(D - 1);

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int b = 0; b < IW; b++) begin
            r[b] = v[IW-1-b];
        end
        return r;
    endfunction

    logic [IW-1:0] idx_q, idx_d;
    logic          fill_full_q, fill_full_d;
    logic          hold_valid_q, hold_valid_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   frames_done_q, frames_done_d;
    logic [N-1:0]  fbuf_q [D];
    logic [N-1:0]  fbuf_d [D];
    logic [N-1:0]  hbuf_q [D];
    logic [N-1:0]  hbuf_d [D];

    logic          accept;
    logic          complete;
    logic          consume;
    logic          hold_free;
    logic          hold_load;
    logic          pending_xfer;
    logic [N-1:0]  w;
    logic [IW-1:0] lane;

    // Handshake: a word transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, and the source must hold
    // in_data stable while in_valid is high and in_ready is low.
    assign in_ready = !fill_full_q;
    assign accept   = in_valid && !fill_full_q;

    // Single conditional subtract; the source guarantees in_data < 2Q.
    assign w    = (in_data >= Q_N) ? (in_data - Q_N) : in_data;
    assign lane = (BITREV != 0) ? bitrev(idx_q) : idx_q;

    assign complete     = accept && (idx_q == LAST_IDX);
    assign consume      = core_load && hold_valid_q;
    assign hold_free    = !hold_valid_q || core_load;
    assign pending_xfer = fill_full_q && core_load;
    assign hold_load    = (complete && hold_free) || pending_xfer;

    always_comb begin
        for (int i = 0; i < D; i++) begin
            fbuf_d[i] = fbuf_q[i];
        end
        if (accept) begin
            fbuf_d[lane] = w;
        end
    end

    // A pending transfer never coincides with an accept, so fbuf_d equals the
    // frozen frame in that case and one source covers both load paths.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            hbuf_d[i] = hold_load ? fbuf_d[i] : hbuf_q[i];
        end
    end

    always_comb begin
        idx_d         = accept ? idx_q + 1'b1 : idx_q;
        fill_full_d   = fill_full_q;
        hold_valid_d  = hold_valid_q;
        frames_done_d = frames_done_q;
        underrun_d    = underrun_q;
        if (complete && !hold_free) begin
            fill_full_d = 1'b1;
        end else if (pending_xfer) begin
            fill_full_d = 1'b0;
        end
        if (hold_load) begin
            hold_valid_d = 1'b1;
        end else if (consume) begin
            hold_valid_d = 1'b0;
        end
        if (consume) begin
            frames_done_d = frames_done_q + 16'd1;
        end
        if (core_load && !hold_valid_q) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            fill_full_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            underrun_q    <= 1'b0;
            frames_done_q <= '0;
        end else begin
            idx_q         <= idx_d;
            fill_full_q   <= fill_full_d;
            hold_valid_q  <= hold_valid_d;
            underrun_q    <= underrun_d;
            frames_done_q <= frames_done_d;
        end
    end

    // Buffer contents are don't-care after reset; the valid flags gate them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            fbuf_q[i] <= fbuf_d[i];
            hbuf_q[i] <= hbuf_d[i];
        end
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_lane
        assign a[N*gi +: N] = hold_valid_q ? hbuf_q[gi] : '0;
    end

    assign frame_pending = hold_valid_q;
    assign underrun      = underrun_q;
    assign frames_done   = frames_done_q;

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Directed bench for ntt_coeff_loader: one natural-order and one bit-reversed
// instance share stimulus; each scenario task checks its own outputs inline.
module tb_ntt_coeff_loader;

    localparam int N = 17;
    localparam int D = 8;
    localparam int Q = 65537;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_data;
    logic           in_valid;
    logic           core_load;

    logic           in_ready, in_ready_br;
    logic [D*N-1:0] a, a_br;
    logic           frame_pending, frame_pending_br;
    logic           underrun, underrun_br;
    logic [15:0]    frames_done, frames_done_br;

    logic [N-1:0]   exp_q [$];
    logic [N-1:0]   exp_v;
    int             checks;
    int             errors;

    ntt_coeff_loader #(.N(N), .D(D), .Q(Q), .BITREV(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .core_load     (core_load),
        .a             (a),
        .frame_pending (frame_pending),
        .underrun      (underrun),
        .frames_done   (frames_done)
    );

    ntt_coeff_loader #(.N(N), .D(D), .Q(Q), .BITREV(1)) dut_br (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready_br),
        .core_load     (core_load),
        .a             (a_br),
        .frame_pending (frame_pending_br),
        .underrun      (underrun_br),
        .frames_done   (frames_done_br)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] lane_of(input logic [D*N-1:0] v, input int i);
        return v[N*i +: N];
    endfunction

    // Drivers: inputs change on the falling edge, outputs are read there too.
    task automatic step(input logic v, input logic [N-1:0] d, input logic cl);
        in_valid  = v;
        in_data   = d;
        core_load = cl;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic feed_frame(input int base);
        for (int k = 0; k < D; k++) begin
            step(1'b1, N'(base + k), 1'b0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %0b want 0", frame_pending); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %0b want 0", underrun); end
        checks++; if (frames_done !== 16'd0) begin errors++; $display("FAIL reset_frames_done got %0d want 0", frames_done); end
        checks++; if (a !== '0) begin errors++; $display("FAIL reset_a got %h want 0", a); end
    endtask

    task automatic test_natural();
        do_reset();
        for (int k = 0; k < D; k++) begin
            step(1'b1, N'(k), 1'b0);
            if (k == D - 2) begin
                checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL nat_early_pending got %0b want 0", frame_pending); end
            end
            // An idle cycle between some words must not advance the index.
            if (k % 3 == 1) step(1'b0, N'(12345), 1'b0);
        end
        in_valid = 1'b0;
        checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL nat_pending got %0b want 1", frame_pending); end
        for (int i = 0; i < D; i++) exp_q.push_back(N'(i));
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL nat_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
        checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL nat_frames_done got %0d want 1", frames_done); end
        checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL nat_pending_after got %0b want 0", frame_pending); end
        checks++; if (a !== '0) begin errors++; $display("FAIL nat_a_after got %h want 0", a); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL nat_underrun got %0b want 0", underrun); end
    endtask

    task automatic test_bitrev();
        do_reset();
        feed_frame(0);
        exp_q.push_back(17'd0); exp_q.push_back(17'd4); exp_q.push_back(17'd2); exp_q.push_back(17'd6);
        exp_q.push_back(17'd1); exp_q.push_back(17'd5); exp_q.push_back(17'd3); exp_q.push_back(17'd7);
        checks++; if (frame_pending_br !== 1'b1) begin errors++; $display("FAIL br_pending got %0b want 1", frame_pending_br); end
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a_br, i) !== exp_v) begin errors++; $display("FAIL br_lane%0d got %0d want %0d", i, lane_of(a_br, i), exp_v); end
        end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
        checks++; if (frames_done_br !== 16'd1) begin errors++; $display("FAIL br_frames_done got %0d want 1", frames_done_br); end
    endtask

    // 131073 does not fit in 17 bits; 131071 is the largest representable input.
    task automatic test_reduction();
        logic [N-1:0] vin [D];
        vin = '{17'd65536, 17'd65537, 17'd65540, 17'd131071, 17'd5, 17'd65535, 17'd131070, 17'd0};
        exp_q.push_back(17'd65536); exp_q.push_back(17'd0); exp_q.push_back(17'd3); exp_q.push_back(17'd65534);
        exp_q.push_back(17'd5); exp_q.push_back(17'd65535); exp_q.push_back(17'd65533); exp_q.push_back(17'd0);
        do_reset();
        for (int k = 0; k < D; k++) step(1'b1, vin[k], 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL red_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 2 * D; k++) begin
            step(1'b1, N'(100 + k), 1'b0);
            if (k == D - 1) begin
                checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL st_pending8 got %0b want 1", frame_pending); end
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_ready8 got %0b want 1", in_ready); end
            end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL st_ready16 got %0b want 0", in_ready); end
        // Offered while stalled; must not be taken.
        step(1'b1, N'(999), 1'b0);
        for (int i = 0; i < D; i++) exp_q.push_back(N'(100 + i));
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL st_f1_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
        step(1'b1, N'(999), 1'b1);
        in_valid  = 1'b0;
        core_load = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_ready_back got %0b want 1", in_ready); end
        checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL st_f2_pending got %0b want 1", frame_pending); end
        checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL st_frames1 got %0d want 1", frames_done); end
        for (int i = 0; i < D; i++) exp_q.push_back(N'(108 + i));
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL st_f2_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
        checks++; if (frames_done !== 16'd2) begin errors++; $display("FAIL st_frames2 got %0d want 2", frames_done); end
        checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL st_pending_end got %0b want 0", frame_pending); end
        feed_frame(200);
        for (int i = 0; i < D; i++) exp_q.push_back(N'(200 + i));
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL st_f3_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        feed_frame(10);
        for (int k = 0; k < D; k++) begin
            step(1'b1, N'(20 + k), (k == D - 1) ? 1'b1 : 1'b0);
        end
        in_valid  = 1'b0;
        core_load = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b want 1", in_ready); end
        checks++; if (frame_pending !== 1'b1) begin errors++; $display("FAIL b2b_pending got %0b want 1", frame_pending); end
        checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL b2b_frames got %0d want 1", frames_done); end
        for (int i = 0; i < D; i++) exp_q.push_back(N'(20 + i));
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL b2b_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
    endtask

    task automatic test_underrun();
        do_reset();
        checks++; if (a !== '0) begin errors++; $display("FAIL ur_a got %h want 0", a); end
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set got %0b want 1", underrun); end
        checks++; if (frames_done !== 16'd0) begin errors++; $display("FAIL ur_frames got %0d want 0", frames_done); end
        feed_frame(40);
        step(1'b0, '0, 1'b1);
        core_load = 1'b0;
        checks++; if (frames_done !== 16'd1) begin errors++; $display("FAIL ur_frames_after got %0d want 1", frames_done); end
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got %0b want 1", underrun); end
        do_reset();
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %0b want 0", underrun); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, N'(50 + k), 1'b0);
        rst = 1'b1;
        step(1'b1, N'(777), 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_ready got %0b want 1", in_ready); end
        checks++; if (frame_pending !== 1'b0) begin errors++; $display("FAIL mr_pending got %0b want 0", frame_pending); end
        feed_frame(70);
        for (int i = 0; i < D; i++) exp_q.push_back(N'(70 + i));
        for (int i = 0; i < D; i++) begin
            exp_v = exp_q.pop_front();
            checks++; if (lane_of(a, i) !== exp_v) begin errors++; $display("FAIL mr_lane%0d got %0d want %0d", i, lane_of(a, i), exp_v); end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        core_load = 1'b0;
        @(negedge clk);
        test_reset();
        test_natural();
        test_bitrev();
        test_reduction();
        test_stream();
        test_back_to_back();
        test_underrun();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
